// File: rtl/fft_frame_source.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_source
// Description : Keeps the most recent 2^LGWIDTH real audio samples in a
//               circular buffer and, every i_hop accepted samples, replays
//               the whole frame oldest-first on the (ce, sample, sync)
//               complex stream feeding the forward FFT.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_source #(
  parameter int IWIDTH  = 16,
  parameter int WIDTH   = 21,
  parameter int LGWIDTH = 9
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_valid,
  input  logic [IWIDTH-1:0]    i_sample,
  input  logic [LGWIDTH:0]     i_hop,
  output logic                 o_ce,
  output logic [2*WIDTH-1:0]   o_sample,
  output logic                 o_sync,
  output logic                 o_overrun
);

  localparam int                 c_n          = 1 << LGWIDTH;
  localparam logic [LGWIDTH:0]   c_full       = {1'b1, {LGWIDTH{1'b0}}};
  localparam logic [LGWIDTH:0]   c_prime_last = c_full - (LGWIDTH+1)'(1);
  localparam logic [LGWIDTH-1:0] c_last_rd    = '1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Sample buffer: plain dual-port RAM, never reset
  logic [IWIDTH-1:0]  r_mem [c_n];
  logic [IWIDTH-1:0]  r_rd_data;

  // Write side bookkeeping
  logic [LGWIDTH-1:0] r_wp;
  logic [LGWIDTH:0]   r_fill;
  logic [LGWIDTH:0]   r_hop_cnt;

  // Read side bookkeeping
  logic [LGWIDTH-1:0] r_rp;
  logic [LGWIDTH-1:0] r_rd_cnt;
  logic               r_rd_valid;
  logic               r_rd_first;

  // Output registers
  logic               r_ce;
  logic               r_sync;
  logic               r_overrun;
  logic [2*WIDTH-1:0] r_out;

  logic [LGWIDTH:0]   w_eff_hop;
  logic [LGWIDTH:0]   w_hop_inc;
  logic               w_trig;
  logic               w_rd_en;
  logic               w_load;
  logic               w_drop;
  logic [WIDTH-1:0]   w_re;

  // An out-of-range hop (0 or larger than the frame) means one frame per N samples
  assign w_eff_hop = ((i_hop == '0) || (i_hop > c_full)) ? c_full : i_hop;
  assign w_hop_inc = r_hop_cnt + (LGWIDTH+1)'(1);

  // Trigger on the write that completes priming, then every effective hop
  assign w_trig = i_valid &&
                  ((r_fill == c_prime_last) ||
                   ((r_fill == c_full) && (w_hop_inc >= w_eff_hop)));

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_state_next;
  end

  // Next-state logic: start, chain or drop frames
  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_load       = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_trig) begin
          w_load       = 1'b1;
          w_state_next = ST_BURST;
        end
      end
      ST_BURST: begin
        w_rd_en = 1'b1;
        if (r_rd_cnt == c_last_rd) begin
          // A trigger in the final read cycle chains straight into the next frame
          if (w_trig) w_load = 1'b1;
          else        w_state_next = ST_IDLE;
        end else if (w_trig) begin
          w_drop = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Write pointer, priming fill level and hop counter
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wp      <= '0;
      r_fill    <= '0;
      r_hop_cnt <= '0;
    end else if (i_valid) begin
      r_wp      <= r_wp + LGWIDTH'(1);
      if (r_fill != c_full) r_fill <= r_fill + (LGWIDTH+1)'(1);
      r_hop_cnt <= w_trig ? '0 : w_hop_inc;
    end
  end

  // Read pointer and read count; a new frame starts just past the triggering write
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rp     <= '0;
      r_rd_cnt <= '0;
    end else if (w_load) begin
      r_rp     <= r_wp + LGWIDTH'(1);
      r_rd_cnt <= '0;
    end else if (w_rd_en) begin
      r_rp     <= r_rp + LGWIDTH'(1);
      r_rd_cnt <= r_rd_cnt + LGWIDTH'(1);
    end
  end

  // Read-first RAM: a same-address write this cycle is not seen by the read
  always_ff @(posedge i_clk) begin
    if (i_valid) r_mem[r_wp] <= i_sample;
    if (w_rd_en) r_rd_data   <= r_mem[r_rp];
  end

  // Track which RAM read carries valid data and which one is bin 0
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_valid <= 1'b0;
      r_rd_first <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_en;
      r_rd_first <= w_rd_en && (r_rd_cnt == '0);
    end
  end

  assign w_re = {{(WIDTH-IWIDTH){r_rd_data[IWIDTH-1]}}, r_rd_data};

  // Output stage: pack {re, im}, zero the bus between valid samples
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ce      <= 1'b0;
      r_sync    <= 1'b0;
      r_overrun <= 1'b0;
      r_out     <= '0;
    end else begin
      r_ce      <= r_rd_valid;
      r_sync    <= r_rd_first;
      r_overrun <= w_drop;
      r_out     <= r_rd_valid ? {w_re, {WIDTH{1'b0}}} : '0;
    end
  end

  assign o_ce      = r_ce;
  assign o_sync    = r_sync;
  assign o_overrun = r_overrun;
  assign o_sample  = r_out;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_frame_source
// Description : Scoreboard bench for fft_frame_source with an 8-sample frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_frame_source;

  localparam int IWIDTH  = 16;
  localparam int WIDTH   = 21;
  localparam int LGWIDTH = 3;
  localparam int N       = 1 << LGWIDTH;

  typedef struct {
    int unsigned        stamp;
    logic               sync;
    logic [2*WIDTH-1:0] data;
  } sb_entry_t;

  logic                 clk     = 1'b0;
  logic                 reset_n = 1'b1;
  logic                 valid   = 1'b0;
  logic [IWIDTH-1:0]    sample  = '0;
  logic [LGWIDTH:0]     hop     = (LGWIDTH+1)'(4);
  logic                 ce;
  logic [2*WIDTH-1:0]   dout;
  logic                 sync;
  logic                 overrun;

  int unsigned          cyc = 0;
  int                   n_checks = 0;
  int                   n_errors = 0;
  int                   ce_count = 0;

  // Reference model state
  sb_entry_t            sb[$];
  int unsigned          ovq[$];
  logic [IWIDTH-1:0]    hist[$];
  int                   fill_m;
  int                   hop_m;
  int unsigned          last_read;
  int unsigned          last_t;

  fft_frame_source #(
    .IWIDTH (IWIDTH),
    .WIDTH  (WIDTH),
    .LGWIDTH(LGWIDTH)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_valid   (valid),
    .i_sample  (sample),
    .i_hop     (hop),
    .o_ce      (ce),
    .o_sample  (dout),
    .o_sync    (sync),
    .o_overrun (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [2*WIDTH-1:0] pack(input logic [IWIDTH-1:0] v);
    logic signed [WIDTH-1:0] re;
    re = WIDTH'($signed(v));
    return {re, {WIDTH{1'b0}}};
  endfunction

  task automatic reset_model();
    fill_m    = 0;
    hop_m     = 0;
    last_read = 0;
    hist.delete();
    sb.delete();
    ovq.delete();
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    reset_model();
    #1;
    check("rst_ce",      64'(ce),      64'd0);
    check("rst_sync",    64'(sync),    64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_sample",  64'(dout),    64'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Drive one sample, then update the model with what that write should cause
  task automatic write_sample(input logic [IWIDTH-1:0] v, input int gap);
    int        eh;
    bit        trig;
    sb_entry_t e;
    valid  = 1'b1;
    sample = v;
    @(posedge clk);
    #1;
    last_t = cyc;
    valid  = 1'b0;
    hist.push_back(v);
    eh   = ((hop == 0) || (int'(hop) > N)) ? N : int'(hop);
    trig = 1'b0;
    hop_m++;
    if (fill_m < N) begin
      fill_m++;
      if (fill_m == N) trig = 1'b1;
    end else if (hop_m >= eh) begin
      trig = 1'b1;
    end
    if (trig) begin
      hop_m = 0;
      if (last_t >= last_read) begin
        last_read = last_t + N;
        for (int k = 0; k < N; k++) begin
          e.stamp = last_t + 2 + k;
          e.sync  = (k == 0);
          e.data  = pack(hist[hist.size() - N + k]);
          sb.push_back(e);
        end
      end else begin
        ovq.push_back(last_t);
      end
    end
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("drain_frames",  64'(sb.size()),  64'd0);
    check("drain_overrun", 64'(ovq.size()), 64'd0);
  endtask

  // Output monitor: every o_ce beat and every overrun pulse must match the model
  always @(negedge clk) begin
    if (reset_n) begin
      if (ce) begin
        ce_count++;
        if (sb.size() == 0) begin
          check("unexpected_ce", 64'(ce), 64'd0);
        end else begin
          sb_entry_t e;
          e = sb.pop_front();
          check("ce_cycle", 64'(cyc),  64'(e.stamp));
          check("sync",     64'(sync), 64'(e.sync));
          check("sample",   64'(dout), 64'(e.data));
        end
      end else begin
        check("idle_out", {22'd0, sync, dout}, 64'd0);
      end
      if (overrun) begin
        if (ovq.size() == 0) check("unexpected_overrun", 64'(overrun), 64'd0);
        else                 check("overrun_cycle", 64'(cyc), 64'(ovq.pop_front()));
      end
    end
  end

  initial begin
    int base;
    int g;
    logic [IWIDTH-1:0] sgn [8];
    sgn = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001,
            16'h0000, 16'h1234, 16'hFFFE, 16'h8001};
    reset_model();
    #2;
    apply_reset();

    // Priming: seven samples must produce nothing
    for (int i = 1; i <= 7; i++) write_sample(IWIDTH'(i), 3);
    repeat (20) @(posedge clk);
    #1;
    check("prime_no_ce", 64'(ce_count), 64'd0);

    // Eighth sample completes priming: frame 1..8
    write_sample(IWIDTH'(8), 3);
    drain();
    check("first_frame_len", 64'(ce_count), 64'(N));

    // Slow hop of four: frame 5..12
    for (int i = 9; i <= 12; i++) write_sample(IWIDTH'(i), 20);
    drain();
    check("second_frame_len", 64'(ce_count), 64'(2 * N));

    // Back-to-back frames with a dropped trigger at sample 12
    apply_reset();
    base = ce_count;
    for (int i = 1; i <= 16; i++) write_sample(IWIDTH'(i), 0);
    drain();
    check("b2b_len", 64'(ce_count - base), 64'(2 * N));

    // Sign extension of extreme values
    apply_reset();
    for (int i = 0; i < 8; i++) write_sample(sgn[i], 0);
    drain();

    // Reset in the middle of a burst
    apply_reset();
    for (int i = 0; i < 8; i++) write_sample(IWIDTH'(16'h0100 + i), 0);
    g = 0;
    while (cyc < last_t + 5 && g < 50) begin
      @(negedge clk);
      g++;
    end
    #2;
    check("bin3_ce", 64'(ce), 64'd1);
    apply_reset();
    base = ce_count;
    for (int i = 0; i < 7; i++) write_sample(IWIDTH'(16'h0200 + i), 1);
    repeat (20) @(posedge clk);
    #1;
    check("post_reset_no_ce", 64'(ce_count - base), 64'd0);
    write_sample(IWIDTH'(16'h0207), 0);
    drain();
    check("post_reset_frame", 64'(ce_count - base), 64'(N));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_frame_source.md
# fft_frame_source

Producer side of the spectral stream: accepts real time-domain audio samples on a valid strobe, keeps the most recent 2^LGWIDTH samples in a circular buffer, and every i_hop new samples replays the full frame as a burst on the (ce, sample, sync) complex stream. Bursts are oldest-first, with sync on the first sample. It sits upstream of the forward FFT and drives the same stream format that the spectral filter stages consume after the transform. Overlapped framing (hop < N) is supported; a trigger that cannot be served is dropped and flagged.

## Interface
- IWIDTH, 16, signed width of input audio sample
- WIDTH, 21, width of each complex component on the output stream
- LGWIDTH, 9, log2 of frame length; N = 2^LGWIDTH
- i_clk  in  1  clock, all logic on rising edge
- i_reset_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  one new audio sample this cycle
- i_sample  in  IWIDTH  signed audio sample
- i_hop  in  LGWIDTH+1  samples between frame triggers; 0 or >N treated as N; quasi-static
- o_ce  out  1  stream sample valid
- o_sample  out  2*WIDTH  {re, im}; re = sign-extended sample, im = 0
- o_sync  out  1  high with o_ce on frame bin 0 only
- o_overrun  out  1  one-cycle pulse: trigger dropped

## Operation
- Buffer: N x IWIDTH dual-port RAM; write pointer wp (LGWIDTH bits, wraps N-1 -> 0), write on i_valid.
- RAM is read-first: same-address read and write in one cycle returns old data.
- Fill counter saturates at N; no trigger while fill < N (priming).
- Hop counter counts accepted samples since last trigger; reset to 0 on every trigger (accepted or dropped).
- Trigger: on the write that makes fill == N for the first time, and thereafter on the write where hop count reaches effective hop.
- States: IDLE, BURST. IDLE + trigger -> BURST, read pointer rp = (address just written + 1) mod N, read count 0.
- BURST: one read per cycle, rp increments with wrap; after N reads -> IDLE, unless a trigger arrives in the last read cycle -> stays BURST, reloads rp/count (back-to-back frames).
- Trigger in BURST before last read cycle: dropped, o_overrun pulses, current burst unaffected.
- Writes continue during BURST; wp never overtakes rp (both advance at most 1/cycle from the same start, read-first), so the frame is exactly the N samples ending at the triggering sample.
- Output packing: re = sign-extend(IWIDTH -> WIDTH), im = 0. o_sample = 0 whenever o_ce is low.

## Timing
- Reset (async assert): o_ce, o_sync, o_overrun, o_sample = 0 immediately; wp, fill, hop count = 0; state IDLE. Buffer contents are not cleared and are unreachable until refilled.
- Reset mid-burst: burst aborted at once; no partial frame resumes after release.
- Trigger write at edge t: reads at t+1..t+N; o_ce high for edges t+2..t+N+1; o_sync at t+2.
- Back-to-back: o_ce is continuous, o_sync every N cycles.
- o_overrun registered: high the cycle after the dropped trigger write.
- Latency from triggering sample to its bin (N-1) output: N+1 cycles.

## Test plan
- LGWIDTH=3: hold reset, release; feed 7 samples -> o_ce, o_sync, o_sample, o_overrun stay 0.
- i_hop=4: feed 1..8 spaced 3 cycles apart -> 8 o_ce cycles, re = 1..8, im = 0, o_sync only with re=1, starting 2 cycles after the 8th write.
- Continue 9..12 spaced 20 cycles apart -> one frame re = 5..12, no overrun.
- i_hop=4, samples 1..16 on consecutive cycles:
  - trigger at sample 12 -> o_overrun single pulse.
  - Frames 1..8 then 9..16 -> 16 contiguous o_ce cycles, o_sync at bins 0 and 8.
  - First frame unaffected by writes during its burst (read-first check).
- i_sample = 16'hFFFF (-1) and 16'h8000 -> re = 21'h1FFFFF and 21'h1F8000, im = 0.
- Assert i_reset_n low at bin 3 of a burst -> all outputs 0 same cycle. After release, 8 new samples are required before the next o_sync.
